// File: rtl/reg_file_sb_pkg.sv
// Shared constants and helpers for the register bank with pending-write scoreboard.
package reg_file_pkg;

   localparam int SP_IDX_DEF = 16;
   localparam int SP_RST_DEF = 1023;
   localparam int ZERO_IDX   = 0;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << res) < value) res++;
      end
      return res;
   endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Read, write and issue signals between the pipeline and the register bank.
interface reg_file_sb_if
   import reg_file_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = clog2(32),
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     iss_valid;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     iss_ready;
   logic                     err;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr,
      input  rd_data, rd_busy, iss_ready, err
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr,
      output rd_data, rd_busy, iss_ready, err
   );
endinterface

// File: rtl/reg_file_sb_pend_counter.sv
// Saturating up/down count of writes still in flight for one register.
module pend_counter
   import reg_file_pkg::*;
#(
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   output logic [PEND_W-1:0] cnt,
   output logic              full,
   output logic              nonzero
);
   logic inc_eff;
   logic dec_eff;

   assign full    = (cnt == {PEND_W{1'b1}});
   assign nonzero = (cnt != '0);
   assign dec_eff = dec & nonzero;
   // a full counter may only take an issue when a retire frees a slot
   assign inc_eff = inc & (~full | dec_eff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc_eff && !dec_eff) begin
         cnt <= cnt + PEND_W'(1);
      end else if (dec_eff && !inc_eff) begin
         cnt <= cnt - PEND_W'(1);
      end
   end
endmodule

// File: rtl/reg_file_sb.sv
// Register bank with combinational read ports, write bypass, hardwired zero
// register and per-register pending-write counters for hazard detection.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int SP_IDX   = SP_IDX_DEF,
   parameter int SP_RST   = SP_RST_DEF,
   parameter int PEND_W   = 2,
   parameter int BYPASS   = 1
) (
   input logic         clk,
   input logic         rst,
   reg_file_sb_if.slave bus
);
   localparam int ADDR_W = clog2(NUM_REGS);

   logic [DATA_W-1:0]        regs    [NUM_REGS];
   logic [PEND_W-1:0]        cnt     [NUM_REGS];
   logic                     full_v  [NUM_REGS];
   logic                     nz_v    [NUM_REGS];
   logic [NUM_REGS-1:0]      inc_v;
   logic [NUM_REGS-1:0]      dec_v;
   logic                     iss_ready;
   logic                     iss_fire;
   logic                     wr_ok;
   logic                     err;
   logic [ADDR_W-1:0]        a;
   logic [NUM_RD*DATA_W-1:0] rd_data_v;
   logic [NUM_RD-1:0]        rd_busy_v;

   // true for addresses that map onto a real, writable register
   function automatic logic live(input logic [ADDR_W-1:0] addr);
      return (32'(addr) != ZERO_IDX) && (32'(addr) < NUM_REGS);
   endfunction

   assign wr_ok = bus.wr_en && live(bus.wr_addr);

   always_comb begin
      iss_ready = 1'b1;
      if (live(bus.iss_addr) && full_v[bus.iss_addr] &&
          !(bus.wr_en && bus.wr_addr == bus.iss_addr)) begin
         iss_ready = 1'b0;
      end
   end

   assign iss_fire = bus.iss_valid && iss_ready && live(bus.iss_addr);

   always_comb begin
      inc_v = '0;
      dec_v = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         inc_v[r] = iss_fire && (bus.iss_addr == ADDR_W'(r));
         dec_v[r] = wr_ok && (bus.wr_addr == ADDR_W'(r));
      end
   end

   assign cnt[0]    = '0;
   assign full_v[0] = 1'b0;
   assign nz_v[0]   = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
      pend_counter #(.PEND_W(PEND_W)) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .inc     (inc_v[r]),
         .dec     (dec_v[r]),
         .cnt     (cnt[r]),
         .full    (full_v[r]),
         .nonzero (nz_v[r])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= (r == SP_IDX) ? DATA_W'(SP_RST) : '0;
         end
      end else if (wr_ok) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (wr_ok && !nz_v[bus.wr_addr]) begin
         err <= 1'b1;
      end
   end

   // a retiring write that empties the counter clears busy in the same cycle
   always_comb begin
      rd_data_v = '0;
      rd_busy_v = '0;
      a         = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         a = bus.rd_addr[k*ADDR_W +: ADDR_W];
         if (live(a)) begin
            rd_data_v[k*DATA_W +: DATA_W] = regs[a];
            rd_busy_v[k]                  = nz_v[a];
            if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == a)) begin
               rd_data_v[k*DATA_W +: DATA_W] = bus.wr_data;
               if ((cnt[a] == PEND_W'(1)) && !inc_v[a]) rd_busy_v[k] = 1'b0;
            end
         end
      end
   end

   assign bus.rd_data   = rd_data_v;
   assign bus.rd_busy   = rd_busy_v;
   assign bus.iss_ready = iss_ready;
   assign bus.err       = err;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scenarios for reg_file_sb: reset values, zero register, saturation,
// bypass of busy/data, sticky error and asynchronous reset.
module tb_reg_file_sb;
   import reg_file_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

   reg_file_sb #(
      .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .SP_IDX(16), .SP_RST(1023),
      .PEND_W(2), .BYPASS(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic idle();
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.iss_valid = 1'b0;
      bus.iss_addr  = '0;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      bus.rd_addr = {a1, a0};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      set_rd(5'd16, 5'd5);
      #12;
      @(negedge clk);
      rst = 1'b0;
      bus.iss_addr = 5'd4;
      #1;
      if (bus.rd_data[31:0] !== 32'd1023) begin bad++; $display("FAIL reset_r16 got=%h want=%h", bus.rd_data[31:0], 32'd1023); end
      total++;
      if (bus.rd_data[63:32] !== 32'd0) begin bad++; $display("FAIL reset_r5 got=%h want=%h", bus.rd_data[63:32], 32'd0); end
      total++;
      if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b want=00", bus.rd_busy); end
      total++;
      if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL reset_iss_ready got=%b want=1", bus.iss_ready); end
      total++;
      if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
      total++;
   endtask

   task automatic test_zero_and_neg();
      @(negedge clk); idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hDEAD_BEEF;
      set_rd(5'd0, 5'd0);
      #1;
      if (bus.rd_data[31:0] !== 32'd0) begin bad++; $display("FAIL r0_same_cycle got=%h want=0", bus.rd_data[31:0]); end
      total++;
      @(negedge clk); idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
      #1;
      if (bus.rd_data[31:0] !== 32'd0) begin bad++; $display("FAIL r0_after_write got=%h want=0", bus.rd_data[31:0]); end
      total++;
      if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL r0_issue_ready got=%b want=1", bus.iss_ready); end
      total++;
      @(negedge clk); idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
      @(negedge clk); idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = -32'sd7;
      set_rd(5'd3, 5'd3);
      #1;
      if (bus.rd_data[31:0] !== 32'hFFFF_FFF9) begin bad++; $display("FAIL r3_bypass_p0 got=%h want=fffffff9", bus.rd_data[31:0]); end
      total++;
      if (bus.rd_data[63:32] !== 32'hFFFF_FFF9) begin bad++; $display("FAIL r3_bypass_p1 got=%h want=fffffff9", bus.rd_data[63:32]); end
      total++;
      if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL r3_bypass_busy got=%b want=00", bus.rd_busy); end
      total++;
      @(negedge clk); idle();
      #1;
      if (bus.rd_data[31:0] !== 32'hFFFF_FFF9) begin bad++; $display("FAIL r3_stored got=%h want=fffffff9", bus.rd_data[31:0]); end
      total++;
      if (bus.err !== 1'b0) begin bad++; $display("FAIL r3_err got=%b want=0", bus.err); end
      total++;
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle();
         bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
         set_rd(5'd4, 5'd4);
         #1;
         if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL sat_issue%0d_ready got=%b want=1", i, bus.iss_ready); end
         total++;
         if (bus.rd_busy[0] !== (i != 0)) begin bad++; $display("FAIL sat_issue%0d_busy got=%b want=%b", i, bus.rd_busy[0], (i != 0)); end
         total++;
      end
      @(negedge clk); idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
      #1;
      if (bus.iss_ready !== 1'b0) begin bad++; $display("FAIL sat_full_ready got=%b want=0", bus.iss_ready); end
      total++;
      if (bus.rd_busy !== 2'b11) begin bad++; $display("FAIL sat_full_busy got=%b want=11", bus.rd_busy); end
      total++;
      @(negedge clk); idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'd11;
      #1;
      if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL sat_retire_ready got=%b want=1", bus.iss_ready); end
      total++;
      if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sat_retire_busy got=%b want=1", bus.rd_busy[0]); end
      total++;
      if (bus.rd_data[31:0] !== 32'd11) begin bad++; $display("FAIL sat_retire_data got=%h want=%h", bus.rd_data[31:0], 32'd11); end
      total++;
      @(negedge clk); idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
      #1;
      if (bus.iss_ready !== 1'b0) begin bad++; $display("FAIL sat_still_full got=%b want=0", bus.iss_ready); end
      total++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle();
         bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'd100 + 32'(i);
         #1;
         if (bus.rd_busy[0] !== (i != 2)) begin bad++; $display("FAIL sat_drain%0d_busy got=%b want=%b", i, bus.rd_busy[0], (i != 2)); end
         total++;
      end
      @(negedge clk); idle();
      #1;
      if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL sat_empty_busy got=%b want=00", bus.rd_busy); end
      total++;
      if (bus.rd_data[31:0] !== 32'd102) begin bad++; $display("FAIL sat_last_data got=%h want=%h", bus.rd_data[31:0], 32'd102); end
      total++;
      if (bus.err !== 1'b0) begin bad++; $display("FAIL sat_err got=%b want=0", bus.err); end
      total++;
   endtask

   task automatic test_bypass_r7();
      @(negedge clk); idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
      set_rd(5'd7, 5'd7);
      #1;
      if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL r7_pre_busy got=%b want=0", bus.rd_busy[0]); end
      total++;
      @(negedge clk); idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'd5;
      #1;
      if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL r7_iss_wr_busy got=%b want=1", bus.rd_busy[0]); end
      total++;
      if (bus.rd_data[31:0] !== 32'd5) begin bad++; $display("FAIL r7_iss_wr_data got=%h want=%h", bus.rd_data[31:0], 32'd5); end
      total++;
      @(negedge clk); idle();
      #1;
      if (bus.rd_busy !== 2'b11) begin bad++; $display("FAIL r7_still_busy got=%b want=11", bus.rd_busy); end
      total++;
      @(negedge clk); idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'd42;
      #1;
      if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL r7_retire_busy got=%b want=0", bus.rd_busy[0]); end
      total++;
      if (bus.rd_data[31:0] !== 32'd42) begin bad++; $display("FAIL r7_retire_data got=%h want=%h", bus.rd_data[31:0], 32'd42); end
      total++;
      @(negedge clk); idle();
      #1;
      if (bus.rd_data[63:32] !== 32'd42) begin bad++; $display("FAIL r7_stored got=%h want=%h", bus.rd_data[63:32], 32'd42); end
      total++;
      if (bus.err !== 1'b0) begin bad++; $display("FAIL r7_err got=%b want=0", bus.err); end
      total++;
   endtask

   task automatic test_err();
      @(negedge clk); idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h0000_1234;
      set_rd(5'd9, 5'd9);
      #1;
      if (bus.err !== 1'b0) begin bad++; $display("FAIL err_before_edge got=%b want=0", bus.err); end
      total++;
      @(negedge clk); idle();
      #1;
      if (bus.err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", bus.err); end
      total++;
      if (bus.rd_data[31:0] !== 32'h0000_1234) begin bad++; $display("FAIL err_r9_data got=%h want=00001234", bus.rd_data[31:0]); end
      total++;
      if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL err_r9_busy got=%b want=00", bus.rd_busy); end
      total++;
      repeat (3) @(negedge clk);
      #1;
      if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err); end
      total++;
   endtask

   task automatic test_async_rst();
      @(negedge clk); idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd16; bus.wr_data = 32'd5;
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd2;
      @(negedge clk); idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd2;
      set_rd(5'd16, 5'd2);
      @(negedge clk); idle();
      bus.iss_addr = 5'd2;
      #1;
      if (bus.rd_data[31:0] !== 32'd5) begin bad++; $display("FAIL arst_pre_r16 got=%h want=%h", bus.rd_data[31:0], 32'd5); end
      total++;
      if (bus.rd_busy !== 2'b10) begin bad++; $display("FAIL arst_pre_busy got=%b want=10", bus.rd_busy); end
      total++;
      #2;
      rst = 1'b1;
      #1;
      if (bus.rd_data[31:0] !== 32'd1023) begin bad++; $display("FAIL arst_r16 got=%h want=%h", bus.rd_data[31:0], 32'd1023); end
      total++;
      if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL arst_busy got=%b want=00", bus.rd_busy); end
      total++;
      if (bus.err !== 1'b0) begin bad++; $display("FAIL arst_err got=%b want=0", bus.err); end
      total++;
      if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL arst_iss_ready got=%b want=1", bus.iss_ready); end
      total++;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd16; bus.wr_data = 32'd77;
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd2;
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      if (bus.rd_data[31:0] !== 32'd1023) begin bad++; $display("FAIL arst_write_lost got=%h want=%h", bus.rd_data[31:0], 32'd1023); end
      total++;
      if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL arst_issue_lost got=%b want=00", bus.rd_busy); end
      total++;
   endtask

   initial begin
      test_reset();
      test_zero_and_neg();
      test_saturate();
      test_bypass_r7();
      test_err();
      test_async_rst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register bank with a per-register pending-write scoreboard, replacing the fixed 17-entry bank in the single-cycle/pipelined CPU datapath. It provides NUM_RD combinational read ports, one synchronous write port, a hardwired zero register, a special return/stack register with a non-zero reset value, and optional write-to-read bypass. The scoreboard tracks in-flight writes so the pipeline's hazard logic reads per-port busy flags directly from the bank.

## Interface
- DATA_W, 32, register width (signed data)
- NUM_REGS, 32, number of registers; ADDR_W = clog2(NUM_REGS)
- NUM_RD, 2, number of read ports (1..4)
- SP_IDX, 16, index of special return register
- SP_RST, 1023, reset value of register SP_IDX
- PEND_W, 2, width of each pending-write counter
- BYPASS, 1, 1 = same-cycle write data visible on reads
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k register has an outstanding write
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- iss_valid  in  1  issue request: mark iss_addr as pending producer
- iss_addr  in  ADDR_W  destination being issued
- iss_ready  out  1  issue accepted this cycle
- err  out  1  sticky: write retired to a non-pending register

## Operation
- Reset: every register 0 except R[SP_IDX] = SP_RST; all counters 0; err = 0. rd_data after reset shows those values, rd_busy = 0, iss_ready = 1.
- R[0] always reads 0; writes and issues to address 0 are ignored (no counter change, no err). Issue to 0 is always accepted.
- Addresses >= NUM_REGS: reads return 0, busy 0; writes and issues ignored; issue accepted.
- Write: wr_en at a rising edge stores wr_data into R[wr_addr].
- Pending counter cnt[r]: inc = iss_valid & iss_ready & iss_addr==r; dec = wr_en & wr_addr==r & cnt[r]!=0; next = cnt + inc - dec. Simultaneous inc and dec on the same register leaves cnt unchanged.
- iss_ready = !(cnt[iss_addr] == max) | (wr_en & wr_addr==iss_addr), i.e. a saturated counter accepts an issue only when a retiring write frees a slot in the same cycle. iss_ready is combinational; handshake fires on iss_valid & iss_ready.
- Write with cnt==0 (register non-zero, in range): data still written, cnt stays 0, err set; err clears only on rst.
- Read port k: if BYPASS and wr_en and wr_addr==rd_addr[k] and address valid and non-zero, rd_data = wr_data, else R[rd_addr[k]]. rd_busy[k] = cnt!=0, except with BYPASS it is 0 when that same-cycle write takes cnt from 1 to 0 with no concurrent issue.
- With BYPASS=0, read data and busy reflect state before the edge.

## Timing
- Reads: 0-cycle combinational from addresses and array/counter state.
- Write and counter update: 1 cycle; visible after the next rising edge (bypass aside).
- rst asserts asynchronously mid-operation: all state returns to reset values immediately; writes or issues in that cycle are lost.
- Multiple read ports may address the same register; each is independent.

## Structure
- Package reg_file_pkg: clog2 function for ADDR_W, default SP_IDX/SP_RST constants, a zero-register index constant.
- Sub-module pend_counter (PEND_W-bit saturating up/down counter, inputs inc/dec, outputs cnt, full, nonzero), instantiated once per register 1..NUM_REGS-1.
- Array, bypass muxes, issue handshake and err live in the top.

## Test plan
- Reset then read R[16] and R[5] -> 1023 and 0; rd_busy=0, iss_ready=1, err=0.
- Write 0xDEAD_BEEF to R[0], read R[0] -> 0; write -7 to R[3], read -> 0xFFFF_FFF9 next cycle, and same cycle with BYPASS=1.
- Issue R[4] three times (PEND_W=2): rd_busy on R[4]=1, cnt=3, fourth issue iss_ready=0; fourth issue with concurrent write to R[4] -> accepted, cnt stays 3.
- Issue R[7] once, write R[7]=42 in the next cycle with BYPASS=1 -> busy 0 and data 42 in that write cycle; issue and write R[7] same cycle -> busy remains 1.
- Write R[9] with no issue -> R[9] updated, err=1 and stays 1 until rst.
- Assert rst asynchronously between edges with R[16] written to 5 and cnt[2]=2 -> R[16]=1023, busy 0, err 0 immediately.
